event_readout_sequencer: RTL
============================

// Module: event_readout_sequencer
// PURPOSE
//  Sequences one drift-tube event from trigger to FIFO: times the drift window after the
//  latched scintillator coincidence, snapshots all 32 tube cycle counts, clears the tubes,
//  then streams a tagged header plus per-channel words into the 16-bit readout FIFO with
//  full-flag backpressure. Sits between the scintillator latch/Tube array and fifo16x1024.
// PARAMETERS
//  WINDOW_CYCLES  256  clk100 cycles in WINDOW before snapshot (legal 2..65535)
//  CLR_HOLD       11   extra cycles clr_tubes stays high after the last data word (legal >=1)
//  SKIP_EMPTY     0    1: channels with count 8'h00 produce no word; 0: all 32 words written
//  HDR_TAG        8'hF0 upper byte of the event header word
// PORTS
//  clk100        in   1    system clock, 100 MHz
//  rst_n         in   1    asynchronous reset, active low
//  trig_latched  in   1    scintillator latch output; high = event in progress
//  tube_data     in   256  channel k cycle count at [8k+7:8k], k = 0..31
//  fifo_full     in   1    FIFO full flag, same clock domain
//  fifo_din      out  16   FIFO write data
//  fifo_wr_en    out  1    FIFO write strobe; one word per high cycle
//  clr_tubes     out  1    clear to latch and tubes, active high
//  busy          out  1    high in every state except IDLE
//  evt_count     out  8    events written, wraps 255 -> 0
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE, clr_tubes=1, fifo_wr_en=0, fifo_din=0, busy=0,
//   evt_count=0, snapshot=0. clr_tubes drops on first clk100 edge after release.
//  FSM: IDLE -> WINDOW -> CAPTURE -> HEADER -> DATA -> CLEAR -> IDLE.
//  IDLE: trig_latched sampled 1 -> WINDOW with win_cnt=0.
//  WINDOW: win_cnt++ each cycle; at win_cnt==WINDOW_CYCLES-1 -> CAPTURE.
//   trig_latched dropping mid-window is ignored; window runs to completion.
//  CAPTURE: one cycle; tube_data registered into a 256-bit snapshot; clr_tubes -> 1.
//   clr_tubes stays 1 through HEADER, DATA and CLEAR.
//  HEADER: word {HDR_TAG, evt_count} pending; on write evt_count++ -> DATA, ch=0.
//  DATA: word {3'b100, ch[4:0], snap[ch]} pending; on write ch++; after ch 31 -> CLEAR.
//   SKIP_EMPTY=1: channels with snap[ch]==0 consume 1 cycle each, no word, no write.
//  CLEAR: hold_cnt counts CLR_HOLD cycles; then -> IDLE only when trig_latched==0,
//   otherwise wait in CLEAR (clr_tubes kept high) until it drops. clr_tubes=0 in IDLE.
//  Write handshake: fifo_wr_en = word_pending & ~fifo_full (combinational on registered
//   state and fifo_full). fifo_din stable while pending. Word advances only when written.
//   fifo_full high: FSM stalls on the pending word indefinitely; no word dropped or
//   repeated; fifo_din holds its value.
//  Throughput: with fifo_full=0, HEADER plus 32 DATA words are written on 33 consecutive cycles.
//  Latency: trig_latched first sampled high at edge t -> CAPTURE at t+WINDOW_CYCLES+1;
//   header write at t+WINDOW_CYCLES+2.
//  New trigger while busy: not accepted; the latch is held cleared until IDLE.
//  Reset mid-event: abandons event immediately; no partial word written after reset.
//  evt_count counts headers written, including events whose data words stall.
// TESTING
//  1 Reset then trig_latched=1 at t0, fifo_full=0, ch k data=k+1 -> header 16'hF000 at
//    t0+258, then 16'h8001..16'h9F20 on 32 consecutive cycles, evt_count=1.
//  2 As 1, but fifo_full=1 for 5 cycles starting at ch 10 -> fifo_wr_en low 5 cycles,
//    fifo_din=16'h8A0B held, stream resumes with no loss or duplicate.
//  3 SKIP_EMPTY=1, only ch 3=8'h40 and ch 30=8'h07 nonzero -> exactly 3 writes:
//    16'hF000, 16'h8340, 16'h9E07.
//  4 trig_latched held high through CLEAR -> clr_tubes stays 1, no second event until
//    it drops; then IDLE, clr_tubes=0, next trigger produces header 16'hF001.
//  5 rst_n low during DATA at ch 12 -> outputs take reset values asynchronously; next
//    event header is 16'hF000.
//  6 256 back-to-back events -> evt_count wraps to 0; 257th header is 16'hF000.

Source files
------------

// File: rtl/event_readout_sequencer_if.sv
// Readout FIFO write port: data, write strobe and full-flag backpressure.
interface event_readout_sequencer_if;
    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;

    modport master (output fifo_din, output fifo_wr_en, input fifo_full);
    modport slave  (input fifo_din, input fifo_wr_en, output fifo_full);
endinterface

// File: rtl/event_readout_sequencer.sv
// Drift-tube event readout: window timing, tube snapshot, tube clear and
// tagged header + per-channel word stream into the readout FIFO.
module event_readout_sequencer #(
    parameter int unsigned WINDOW_CYCLES = 256,
    parameter int unsigned CLR_HOLD      = 11,
    parameter bit          SKIP_EMPTY    = 1'b0,
    parameter logic [7:0]  HDR_TAG       = 8'hF0
) (
    input  logic                        clk100,
    input  logic                        rst_n,
    input  logic                        trig_latched,
    input  logic [255:0]                tube_data,
    event_readout_sequencer_if.master   fifo,
    output logic                        clr_tubes,
    output logic                        busy,
    output logic [7:0]                  evt_count
);

    localparam int unsigned WIN_W  = 16;
    localparam int unsigned HOLD_W = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
    localparam int unsigned CH_W   = 5;
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLR_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WINDOW  = 3'd1,
        CAPTURE = 3'd2,
        HEADER  = 3'd3,
        DATA    = 3'd4,
        CLEAR   = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [WIN_W-1:0]  win_cnt, win_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [CH_W-1:0]   ch, ch_n;
    logic [255:0]      snapshot, snap_n;
    logic [7:0]        evt_n;
    logic [7:0]        cur;
    logic              pending;
    logic              skip;
    logic [15:0]       word;

    assign cur = snapshot[{ch, 3'b000} +: 8];

    // State and datapath registers; reset abandons any event in flight.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_cnt   <= '0;
            hold_cnt  <= '0;
            ch        <= '0;
            snapshot  <= '0;
            evt_count <= '0;
            clr_tubes <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            win_cnt   <= win_n;
            hold_cnt  <= hold_n;
            ch        <= ch_n;
            snapshot  <= snap_n;
            evt_count <= evt_n;
            clr_tubes <= (state_n == HEADER) || (state_n == DATA) || (state_n == CLEAR);
            busy      <= (state_n != IDLE);
        end
    end

    // Next-state, pending word and write handshake; a word advances only when written.
    always_comb begin
        state_n = state;
        win_n   = win_cnt;
        hold_n  = hold_cnt;
        ch_n    = ch;
        snap_n  = snapshot;
        evt_n   = evt_count;
        pending = 1'b0;
        skip    = 1'b0;
        word    = '0;
        case (state)
            IDLE: begin
                if (trig_latched) begin
                    state_n = WINDOW;
                    win_n   = '0;
                end
            end
            WINDOW: begin
                if (win_cnt == WIN_LAST) begin
                    state_n = CAPTURE;
                end else begin
                    win_n = win_cnt + WIN_W'(1);
                end
            end
            CAPTURE: begin
                snap_n  = tube_data;
                state_n = HEADER;
            end
            HEADER: begin
                pending = 1'b1;
                word    = {HDR_TAG, evt_count};
                if (!fifo.fifo_full) begin
                    evt_n   = evt_count + 8'd1;
                    ch_n    = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                skip    = SKIP_EMPTY && (cur == 8'h00);
                pending = !skip;
                word    = {3'b100, ch, cur};
                if (skip || !fifo.fifo_full) begin
                    if (ch == CH_W'(31)) begin
                        state_n = CLEAR;
                        hold_n  = '0;
                    end else begin
                        ch_n = ch + CH_W'(1);
                    end
                end
            end
            CLEAR: begin
                if (hold_cnt == HOLD_LAST) begin
                    if (!trig_latched) begin
                        state_n = IDLE;
                    end
                end else begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        fifo.fifo_wr_en = pending & ~fifo.fifo_full;
        fifo.fifo_din   = pending ? word : 16'h0000;
    end

endmodule
